// File: rtl/cordic_range_reduce.sv
// Range-reduction front end for the iterative CORDIC sine/cosine core.
// Optional macro CORDIC_RR_LAT_CNT_EN adds the lat_cnt accept-to-result cycle counter.
module cordic_range_reduce #(
  parameter int W            = 32,
  parameter int HALF_TURN    = 1_800_000_000,
  parameter int QUARTER_TURN = 900_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_angle,
  output logic         cordic_s,
  output logic [W-1:0] cordic_angle,
  input  logic         cordic_done,
  input  logic [W-1:0] cordic_sine,
  input  logic [W-1:0] cordic_cosine,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sine,
`ifdef CORDIC_RR_LAT_CNT_EN
  output logic [15:0]  lat_cnt,
`endif
  output logic [W-1:0] out_cosine
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REDUCE = 3'd1,
    FOLD   = 3'd2,
    RUN    = 3'd3,
    DRAIN  = 3'd4,
    OUT    = 3'd5
  } state_t;

  // Wrap constants are one bit wider so the full 32-bit input range cannot overflow.
  localparam logic signed [W:0]   HALF_X    = (W+1)'(HALF_TURN);
  localparam logic signed [W:0]   FULL_X    = HALF_X + HALF_X;
  localparam logic signed [W:0]   NEG_HALF_X = -HALF_X;
  localparam logic signed [W-1:0] HALF_N    = W'(HALF_TURN);
  localparam logic signed [W-1:0] QUARTER_N = W'(QUARTER_TURN);

  state_t               state_r;
  logic signed [W:0]    angle_r;
  logic                 neg_cos_r;
  logic signed [W:0]    reduced_s;
  logic signed [W-1:0]  angle_w_s;
  logic signed [W-1:0]  folded_s;
  logic                 fold_neg_s;

  assign angle_w_s = angle_r[W-1:0];

  // Wrap the latched angle into (-HALF_TURN, HALF_TURN].
  always_comb begin
    reduced_s = angle_r;
    if (angle_r > HALF_X) begin
      reduced_s = angle_r - FULL_X;
    end else if (angle_r <= NEG_HALF_X) begin
      reduced_s = angle_r + FULL_X;
    end else begin
      reduced_s = angle_r;
    end
  end

  // Mirror outer-half angles about +/-90 degrees; sine is preserved, cosine flips sign.
  always_comb begin
    folded_s   = angle_w_s;
    fold_neg_s = 1'b0;
    if (angle_w_s > QUARTER_N) begin
      folded_s   = HALF_N - angle_w_s;
      fold_neg_s = 1'b1;
    end else if (angle_w_s < -QUARTER_N) begin
      folded_s   = -HALF_N - angle_w_s;
      fold_neg_s = 1'b1;
    end else begin
      folded_s   = angle_w_s;
      fold_neg_s = 1'b0;
    end
  end

  // Transaction sequencer with registered handshake and data outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      angle_r      <= '0;
      neg_cos_r    <= 1'b0;
      in_ready     <= 1'b1;
      cordic_s     <= 1'b0;
      cordic_angle <= '0;
      out_valid    <= 1'b0;
      out_sine     <= '0;
      out_cosine   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            angle_r  <= {in_angle[W-1], in_angle};
            in_ready <= 1'b0;
            state_r  <= REDUCE;
          end
        end
        REDUCE: begin
          angle_r <= reduced_s;
          state_r <= FOLD;
        end
        FOLD: begin
          cordic_angle <= folded_s;
          neg_cos_r    <= fold_neg_s;
          cordic_s     <= 1'b1;
          state_r      <= RUN;
        end
        RUN: begin
          if (cordic_done) begin
            out_sine   <= cordic_sine;
            out_cosine <= neg_cos_r ? -cordic_cosine : cordic_cosine;
            cordic_s   <= 1'b0;
            state_r    <= DRAIN;
          end
        end
        DRAIN: begin
          if (!cordic_done) begin
            out_valid <= 1'b1;
            state_r   <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r   <= IDLE;
          in_ready  <= 1'b1;
          cordic_s  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef CORDIC_RR_LAT_CNT_EN
  // Saturating count of cycles from accept until the result is presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_cnt <= 16'h0000;
    end else if (state_r == IDLE && in_valid) begin
      lat_cnt <= 16'h0000;
    end else if ((state_r == REDUCE || state_r == FOLD || state_r == RUN || state_r == DRAIN)
                 && lat_cnt != 16'hFFFF) begin
      lat_cnt <= lat_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_cordic_range_reduce.sv
// Self-checking bench for cordic_range_reduce with a behavioural CORDIC core model.
module tb_cordic_range_reduce;

  localparam real PI = 3.14159265358979323846;
  localparam real GAIN = 1.0000776e7;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_angle;
  logic        cordic_s;
  logic [31:0] cordic_angle;
  logic        cordic_done;
  logic [31:0] cordic_sine;
  logic [31:0] cordic_cosine;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sine;
  logic [31:0] out_cosine;
`ifdef CORDIC_RR_LAT_CNT_EN
  logic [15:0] lat_cnt;
`endif

  int nchk = 0;
  int nerr = 0;
  int core_sin;
  int core_cos;

  cordic_range_reduce dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_angle(in_angle),
    .cordic_s(cordic_s), .cordic_angle(cordic_angle), .cordic_done(cordic_done),
    .cordic_sine(cordic_sine), .cordic_cosine(cordic_cosine),
    .out_valid(out_valid), .out_ready(out_ready), .out_sine(out_sine),
`ifdef CORDIC_RR_LAT_CNT_EN
    .lat_cnt(lat_cnt),
`endif
    .out_cosine(out_cosine)
  );

  always #5 clk = ~clk;

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else return -$rtoi(-x + 0.5);
  endfunction

  // Reference: modular wrap into (-180,180], then mirror into [-90,90].
  function automatic void ref_fold(input logic [31:0] ang, output logic [31:0] ca, output bit neg);
    longint a, r;
    a = longint'($signed(ang));
    r = ((a % 64'sd3600000000) + 64'sd3600000000) % 64'sd3600000000;
    if (r > 64'sd1800000000) r = r - 64'sd3600000000;
    neg = 1'b0;
    if (r > 64'sd900000000) begin
      r = 64'sd1800000000 - r; neg = 1'b1;
    end else if (r < -64'sd900000000) begin
      r = -64'sd1800000000 - r; neg = 1'b1;
    end
    ca = r[31:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, $signed(act), $signed(exp));
    end
  endtask

  task automatic chk_near(input string nm, input logic [31:0] act, input real exp);
    real d;
    nchk++;
    d = $itor($signed(act)) - exp;
    if (d > 2000.0 || d < -2000.0) begin
      nerr++;
      $display("FAIL %s: got %0d, expected about %0d", nm, $signed(act), rnd(exp));
    end
  endtask

  // Core model: random compute latency, done held until start drops, then random release delay.
  initial begin
    int phase, cnt;
    real th;
    phase = 0; cnt = 0;
    cordic_done = 1'b0; cordic_sine = '0; cordic_cosine = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        phase = 0; cordic_done = 1'b0;
      end else begin
        case (phase)
          0: if (cordic_s) begin cnt = $urandom_range(1, 6); phase = 1; end
          1: begin
            if (cnt > 1) cnt--;
            else begin
              th = $itor($signed(cordic_angle)) / 1.0e7 * PI / 180.0;
              core_sin = rnd(GAIN * $sin(th));
              core_cos = rnd(GAIN * $cos(th));
              cordic_sine = core_sin;
              cordic_cosine = core_cos;
              cordic_done = 1'b1;
              cnt = $urandom_range(0, 3);
              phase = 2;
            end
          end
          2: if (!cordic_s) begin
            if (cnt == 0) begin cordic_done = 1'b0; phase = 0; end
            else cnt--;
          end
          default: phase = 0;
        endcase
      end
    end
  end

  task automatic resync();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic run_txn(input logic [31:0] ang, input logic [31:0] ca, input bit neg,
                         input int hold, input bit junk);
    int cyc;
    bit seen_s, stable;
    logic [31:0] s0, c0, exp_cos;
    real deg;
`ifdef CORDIC_RR_LAT_CNT_EN
    logic [15:0] l0;
`endif
    cyc = 0;
    while (!in_ready && cyc < 50) begin @(posedge clk); #1; cyc++; end
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_angle = ang;
    @(posedge clk); #1;
    chk("in_ready_after_accept", 32'(in_ready), 32'd0);
    if (junk) in_angle = $urandom; else in_valid = 1'b0;
    cyc = 0; seen_s = 1'b0;
    while (!out_valid && cyc < 200) begin
      if (cordic_s && !seen_s) begin
        seen_s = 1'b1;
        chk("cordic_angle", cordic_angle, ca);
      end
      @(posedge clk); #1; cyc++;
    end
    in_valid = 1'b0;
    chk("started_core", 32'(seen_s), 32'd1);
    chk("out_valid_timeout", 32'(out_valid), 32'd1);
    if (!out_valid) begin resync(); return; end
`ifdef CORDIC_RR_LAT_CNT_EN
    chk("lat_cnt", 32'(lat_cnt), 32'(cyc));
    l0 = lat_cnt;
`endif
    exp_cos = neg ? -core_cos : core_cos;
    chk("out_sine", out_sine, core_sin);
    chk("out_cosine", out_cosine, exp_cos);
    deg = $itor($signed(ang)) / 1.0e7 * PI / 180.0;
    chk_near("sine_vs_trig", out_sine, GAIN * $sin(deg));
    chk_near("cosine_vs_trig", out_cosine, GAIN * $cos(deg));
    s0 = out_sine; c0 = out_cosine; stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!out_valid || out_sine !== s0 || out_cosine !== c0 || in_ready || cordic_s) stable = 1'b0;
`ifdef CORDIC_RR_LAT_CNT_EN
      if (lat_cnt !== l0) stable = 1'b0;
`endif
    end
    if (hold > 0) chk("out_hold_stable", 32'(stable), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_after_ready", 32'(out_valid), 32'd0);
    chk("in_ready_after_ready", 32'(in_ready), 32'd1);
    chk("out_sine_retained", out_sine, s0);
`ifdef CORDIC_RR_LAT_CNT_EN
    chk("lat_cnt_retained", 32'(lat_cnt), 32'(l0));
`endif
  endtask

  typedef struct {
    logic [31:0] ang;
    logic [31:0] ca;
    bit          neg;
    int          hold;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic [31:0] ra, rca;
    bit rneg;
    int cyc;

    tbl[0]  = '{32'sd300000000,   32'sd300000000,  1'b0, 10};
    tbl[1]  = '{32'sd1500000000,  32'sd300000000,  1'b1, 0};
    tbl[2]  = '{-32'sd2100000000, 32'sd300000000,  1'b1, 2};
    tbl[3]  = '{32'sd1800000000,  32'sd0,          1'b1, 0};
    tbl[4]  = '{-32'sd1800000000, 32'sd0,          1'b1, 1};
    tbl[5]  = '{32'sd900000000,   32'sd900000000,  1'b0, 0};
    tbl[6]  = '{-32'sd900000000,  -32'sd900000000, 1'b0, 0};
    tbl[7]  = '{32'sd900000001,   32'sd899999999,  1'b1, 0};
    tbl[8]  = '{-32'sd900000001,  -32'sd899999999, 1'b1, 0};
    tbl[9]  = '{32'sd1800000001,  -32'sd1,         1'b1, 0};
    tbl[10] = '{-32'sd1800000001, 32'sd1,          1'b1, 0};
    tbl[11] = '{32'sd2147483647,  -32'sd347483647, 1'b1, 0};
    tbl[12] = '{32'h80000000,     32'sd347483648,  1'b1, 0};
    tbl[13] = '{32'sd0,           32'sd0,          1'b0, 0};
    tbl[14] = '{-32'sd1799999999, -32'sd1,         1'b1, 0};

    rst = 1'b1; in_valid = 1'b0; in_angle = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_cordic_s", 32'(cordic_s), 32'd0);
    chk("rst_cordic_angle", cordic_angle, 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sine", out_sine, 32'd0);
    chk("rst_out_cosine", out_cosine, 32'd0);

    for (int i = 0; i < 15; i++)
      run_txn(tbl[i].ang, tbl[i].ca, tbl[i].neg, tbl[i].hold, 1'b0);

    // Reset while the core is running abandons the transaction.
    in_valid = 1'b1; in_angle = 32'sd1500000000;
    @(posedge clk); #1 in_valid = 1'b0;
    cyc = 0;
    while (!cordic_s && cyc < 20) begin @(posedge clk); #1; cyc++; end
    chk("mid_run_reached", 32'(cordic_s), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_cordic_s", 32'(cordic_s), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_sine", out_sine, 32'd0);
    chk("midrst_out_cosine", out_cosine, 32'd0);
`ifdef CORDIC_RR_LAT_CNT_EN
    chk("midrst_lat_cnt", 32'(lat_cnt), 32'd0);
`endif
    run_txn(32'sd300000000, 32'sd300000000, 1'b0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      ref_fold(ra, rca, rneg);
      run_txn(ra, rca, rneg, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/cordic_range_reduce.md
Name: cordic_range_reduce

Overview:
- Front-end sequencer for the iterative CORDIC sine/cosine core.
- Accepts any 32-bit signed angle in degrees x 1e7 over a valid/ready handshake.
- Reduces it to (-180, 180] degrees, then folds it into the core's convergent range [-90, 90] degrees.
- Drives the core's start/done handshake, sign-corrects the returned cosine, and presents sine/cosine downstream over a valid/ready handshake.

Parameters:
- W, 32, angle and result data width; core interface is fixed at 32.
- HALF_TURN, 1_800_000_000, 180 degrees in degrees x 1e7.
- QUARTER_TURN, 900_000_000, 90 degrees in degrees x 1e7.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream angle valid.
- in_ready  out  1  block can accept an angle.
- in_angle  in  32  signed angle, degrees x 1e7.
- cordic_s  out  1  start/hold to core; high = run.
- cordic_angle  out  32  folded angle to core.
- cordic_done  in  1  core result valid.
- cordic_sine  in  32  core sine, x 1e7 scale.
- cordic_cosine  in  32  core cosine, x 1e7 scale.
- out_valid  out  1  result valid downstream.
- out_ready  in  1  downstream accepts result.
- out_sine  out  32  signed sine result.
- out_cosine  out  32  signed cosine result, quadrant-corrected.

Behaviour:
- Reset is asynchronous and active-high, clock is clk. Reset forces state IDLE and clears all internal registers.
  - Outputs after reset: in_ready=1, cordic_s=0, cordic_angle=0, out_valid=0, out_sine=0, out_cosine=0.
  - Reset mid-operation abandons the transaction with no output. The core shares rst and is expected to reset alongside this block.
- FSM states: IDLE, REDUCE, FOLD, RUN, DRAIN, OUT. in_ready is high only in IDLE.
- IDLE: on in_valid=1, latch in_angle, sign-extended to 33 bits, and go to REDUCE.
- REDUCE (1 cycle), computed at 33 bits:
  - a > HALF_TURN: a = a - 2*HALF_TURN.
  - a <= -HALF_TURN: a = a + 2*HALF_TURN.
  - Otherwise a is unchanged.
  - Result is in (-180, 180] degrees and fits 32 bits. Go to FOLD.
- FOLD (1 cycle):
  - a > QUARTER_TURN: a = HALF_TURN - a, neg_cos = 1.
  - a < -QUARTER_TURN: a = -HALF_TURN - a, neg_cos = 1.
  - Otherwise neg_cos = 0.
  - Register a onto cordic_angle and go to RUN. Exactly +/-90 degrees is not folded.
- RUN:
  - cordic_s = 1; cordic_angle is held stable.
  - When cordic_done = 1: capture out_sine = cordic_sine, and out_cosine = neg_cos ? -cordic_cosine : cordic_cosine (32-bit two's complement). Go to DRAIN.
- DRAIN: cordic_s = 0. Wait for cordic_done = 0, then go to OUT. This guarantees the core is back in idle before the next start.
- OUT:
  - out_valid = 1; out_sine and out_cosine are held stable.
  - On out_ready = 1 in the same cycle: go to IDLE, with out_valid low the next cycle.
  - Results remain on out_sine/out_cosine until the next capture.
- in_valid while not in IDLE is ignored; upstream must hold it until in_ready.
- out_ready outside OUT is ignored.
- Latency, accept to out_valid: 2 (REDUCE, FOLD) + core latency + 1 (DRAIN exit) cycles. The core's done/release timing is the only variable.
- No back-to-back pipelining: one transaction in flight.

Optional Feature:
- Macro: CORDIC_RR_LAT_CNT_EN.
- When defined:
  - Adds output lat_cnt (16 bits).
  - Cleared to 0 on accept in IDLE, increments every cycle until the OUT state is entered.
  - Saturates at 16'hFFFF; holds its value through OUT and IDLE.
  - Reset value is 0.
- When undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset during RUN (assert rst with cordic_s=1) -> next cycle in_ready=1, cordic_s=0, out_valid=0, out_sine=out_cosine=0; a new angle 300_000_000 then completes normally.
- in_angle=300_000_000 (30 deg) -> cordic_angle=300_000_000; out_sine ~ 5_000_000, out_cosine ~ 8_660_000 (+/-2000 of value x 1.0000776).
- in_angle=1_500_000_000 (150 deg) -> cordic_angle=300_000_000, neg_cos=1; out_sine ~ +5_000_000, out_cosine ~ -8_660_000.
- in_angle=-2_100_000_000 (-210 deg) -> REDUCE to 1_500_000_000, FOLD to 300_000_000; out_sine ~ +5_000_000, out_cosine ~ -8_660_000.
- in_angle=1_800_000_000 and -1_800_000_000 -> both give cordic_angle=0; out_sine ~ 0, out_cosine ~ -10_000_000; in_angle=900_000_000 -> cordic_angle=900_000_000, not folded.
- Hold out_ready=0 for 10 cycles in OUT -> out_valid stays 1, data stable, in_ready=0, cordic_s=0; out_ready pulse -> IDLE next cycle. With CORDIC_RR_LAT_CNT_EN, lat_cnt stays constant throughout.
